round_tracker: RTL and testbench
================================

ROUND_TRACKER -- requirements
Module: round_tracker

Interface
REQ-001 SHALL have ports, clock and reset first: Clk input 1 system clock; Reset_n input 1 asynchronous active-low reset.
REQ-002 SHALL have inputs, each 1 bit, one cycle wide unless stated:
- frame_tick: once-per-frame vsync pulse.
- trigger: mouse-click pulse.
- hit: duck hitbox contains crosshair, sampled only with trigger.
- new_round, reset_shots, reset_score, reset_birds: control strobes (levels permitted).
REQ-003 SHALL have outputs:
- shots_left, 2 bits.
- no_shots_left, 1 bit.
- bird_shot, 1 bit.
- flew_away, 1 bit.
- game_over, 1 bit.
- score, 16 bits, 4-digit BCD.
- bird_idx, 4 bits, birds resolved.
- hits_map, 10 bits, per-bird hit flags for HUD.
- trk_state, 3 bits, FSM encoding.

Function
REQ-004 SHALL implement FSM IDLE, FLYING, HIT, ESCAPE, GONE (encodings 0-4 on trk_state).
REQ-005 IDLE SHALL go to FLYING on new_round; new_round SHALL be honoured from any state, cleared fly timer, next state FLYING.
REQ-006 FLYING: fly timer SHALL count frame_tick; at FLY_FRAMES (300) ticks, next state GONE.
REQ-007 FLYING with trigger and shots_left>0: shots_left decrements same edge; hit=1 -> HIT; hit=0 and shots_left becomes 0 -> ESCAPE; else stay.
REQ-008 trigger SHALL be ignored when shots_left=0 or state not FLYING.
REQ-009 trigger and timer expiry in the same cycle: trigger SHALL win (shot processed; GONE only if still FLYING next cycle and timer expired).
REQ-010 ESCAPE: escape timer SHALL count ESCAPE_FRAMES (60) frame_ticks then go GONE.
REQ-011 bird_shot SHALL be a level, high exactly while in HIT; flew_away a level, high exactly while in GONE; both held until new_round.
REQ-012 no_shots_left SHALL equal (shots_left==0) AND NOT HIT, so a last-shot hit never reports empty.
REQ-013 On entry to HIT: score += HIT_POINTS (0500 BCD), saturating at 9999; hits_map[bird_idx] set.
REQ-014 On entry to HIT or GONE, bird_idx SHALL increment by 1, saturating at BIRDS_PER_GAME (10).
REQ-015 game_over SHALL be combinational bird_idx==10; registered value visible cycle after final increment.
REQ-016 reset_shots SHALL load shots_left=3; reset_score clears score; reset_birds clears bird_idx and hits_map; each independent, priority over same-cycle updates to that register.
REQ-017 Timers SHALL advance only on frame_tick cycles; no wrap (stop at terminal count).

Reset
REQ-018 Reset_n low SHALL asynchronously force: state IDLE, shots_left=3, score=0, bird_idx=0, hits_map=0, timers 0, all 1-bit outputs 0.
REQ-019 Reset_n assertion mid-round SHALL abandon the round with no score or bird update; release is synchronous to Clk.

Structure
REQ-020 duck_pkg SHALL hold: tracker state enum, SHOTS_PER_ROUND=3, BIRDS_PER_GAME=10, FLY_FRAMES=300, ESCAPE_FRAMES=60, HIT_POINTS=16'h0500.
REQ-021 One sub-module bcd_add4 SHALL provide a 4-digit BCD saturating adder; timers and FSM stay in round_tracker.

Verification
REQ-022 Reset, new_round, trigger hit=1 at frame 10 -> shots_left 2, bird_shot high, score 0x0500, bird_idx 1, hits_map[0]=1.
REQ-023 Three misses -> shots_left 0, no_shots_left high; 60 frame_ticks later flew_away high; score unchanged.
REQ-024 Two misses then hit on third shot -> bird_shot high, no_shots_left stays 0 every cycle.
REQ-025 No trigger for 300 frame_ticks -> flew_away on the 300th; trigger coincident with the 300th tick and hit=1 -> HIT, not GONE.
REQ-026 Ten rounds alternating hit/fly-away with reset_shots between -> bird_idx 10, game_over 1, score 0x2500, hits_map 10'b0101010101; reset_birds+reset_score -> all cleared.
REQ-027 Reset_n low mid-FLYING with shots_left 1 -> IDLE, shots_left 3, outputs 0 immediately, no Clk edge required.

Source files
------------

// File: rtl/duck_pkg.sv
// Shared types and constants for the duck-hunt round tracker.
package duck_pkg;

  localparam int unsigned SHOTS_PER_ROUND = 3;
  localparam int unsigned BIRDS_PER_GAME  = 10;
  localparam int unsigned FLY_FRAMES      = 300;
  localparam int unsigned ESCAPE_FRAMES   = 60;
  localparam logic [15:0] HIT_POINTS      = 16'h0500;

  localparam int unsigned SHOTS_W = 2;
  localparam int unsigned BIRD_W  = 4;
  localparam int unsigned FLY_W   = 9;
  localparam int unsigned ESC_W   = 6;
  localparam int unsigned SCORE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLYING = 3'd1,
    ST_HIT    = 3'd2,
    ST_ESCAPE = 3'd3,
    ST_GONE   = 3'd4
  } trk_state_e;

endpackage

// File: rtl/bcd_add4.sv
// Four-digit BCD adder that clamps to 9999 on overflow.
module bcd_add4
  import duck_pkg::*;
(
  input  logic [SCORE_W-1:0] a_i,
  input  logic [SCORE_W-1:0] b_i,
  output logic [SCORE_W-1:0] sum_o
);

  logic [4:0]         digit;
  logic               carry;
  logic [SCORE_W-1:0] raw;

  // Ripple digit by digit, applying the +6 decimal correction.
  always_comb begin
    digit = 5'd0;
    carry = 1'b0;
    raw   = '0;
    for (int i = 0; i < 4; i++) begin
      digit = 5'(a_i[4*i +: 4]) + 5'(b_i[4*i +: 4]) + 5'(carry);
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[4*i +: 4] = digit[3:0];
    end
    sum_o = carry ? 16'h9999 : raw;
  end

endmodule

// File: rtl/round_tracker.sv
// Tracks one duck per round: shots, fly/escape timers, score and bird tally.
module round_tracker
  import duck_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               trigger,
  input  logic               hit,
  input  logic               new_round,
  input  logic               reset_shots,
  input  logic               reset_score,
  input  logic               reset_birds,
  output logic [SHOTS_W-1:0] shots_left,
  output logic               no_shots_left,
  output logic               bird_shot,
  output logic               flew_away,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [BIRD_W-1:0]  bird_idx,
  output logic [9:0]         hits_map,
  output logic [2:0]         trk_state
);

  localparam logic [FLY_W-1:0]   FLY_END  = FLY_W'(FLY_FRAMES);
  localparam logic [ESC_W-1:0]   ESC_END  = ESC_W'(ESCAPE_FRAMES);
  localparam logic [BIRD_W-1:0]  BIRD_END = BIRD_W'(BIRDS_PER_GAME);
  localparam logic [SHOTS_W-1:0] SHOTS_FULL = SHOTS_W'(SHOTS_PER_ROUND);

  trk_state_e         state_q, state_d;
  logic [FLY_W-1:0]   fly_q, fly_d;
  logic [ESC_W-1:0]   esc_q, esc_d;
  logic [SHOTS_W-1:0] shots_q, shots_d;
  logic [SCORE_W-1:0] score_q, score_d, score_sum;
  logic [BIRD_W-1:0]  bird_idx_q, bird_idx_d;
  logic [9:0]         hits_map_q, hits_map_d;
  logic               nsl_q, nsl_d;
  logic               bird_shot_q, flew_away_q;
  logic               shot_fire, enter_hit, enter_gone;

  bcd_add4 u_bcd_add4 (
    .a_i   (score_q),
    .b_i   (HIT_POINTS),
    .sum_o (score_sum)
  );

  // Round FSM and timers; a shot in FLYING outranks a same-cycle timer expiry.
  always_comb begin
    state_d   = state_q;
    fly_d     = fly_q;
    esc_d     = esc_q;
    shot_fire = 1'b0;
    if (new_round) begin
      state_d = ST_FLYING;
      fly_d   = '0;
      esc_d   = '0;
    end else begin
      case (state_q)
        ST_FLYING: begin
          if (frame_tick && fly_q != FLY_END) fly_d = fly_q + FLY_W'(1);
          if (trigger && shots_q != '0) begin
            shot_fire = 1'b1;
            if (hit)                          state_d = ST_HIT;
            else if (shots_q == SHOTS_W'(1))  state_d = ST_ESCAPE;
          end else if (fly_q == FLY_END ||
                       (frame_tick && fly_q == FLY_END - FLY_W'(1))) begin
            state_d = ST_GONE;
          end
        end
        ST_ESCAPE: begin
          if (frame_tick && esc_q != ESC_END) esc_d = esc_q + ESC_W'(1);
          if (esc_q == ESC_END || (frame_tick && esc_q == ESC_END - ESC_W'(1)))
            state_d = ST_GONE;
        end
        default: ;
      endcase
    end
  end

  // Shot, score and bird bookkeeping; the reset strobes override same-cycle updates.
  always_comb begin
    enter_hit  = (state_d == ST_HIT)  && (state_q != ST_HIT);
    enter_gone = (state_d == ST_GONE) && (state_q != ST_GONE);

    shots_d = shots_q;
    if (reset_shots)    shots_d = SHOTS_FULL;
    else if (shot_fire) shots_d = shots_q - SHOTS_W'(1);

    score_d = score_q;
    if (reset_score)    score_d = '0;
    else if (enter_hit) score_d = score_sum;

    bird_idx_d = bird_idx_q;
    hits_map_d = hits_map_q;
    if (reset_birds) begin
      bird_idx_d = '0;
      hits_map_d = '0;
    end else if (bird_idx_q < BIRD_END) begin
      if (enter_hit)               hits_map_d[bird_idx_q] = 1'b1;
      if (enter_hit || enter_gone) bird_idx_d = bird_idx_q + BIRD_W'(1);
    end

    nsl_d = (shots_d == '0) && (state_d != ST_HIT);
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      fly_q       <= '0;
      esc_q       <= '0;
      shots_q     <= SHOTS_FULL;
      score_q     <= '0;
      bird_idx_q  <= '0;
      hits_map_q  <= '0;
      nsl_q       <= 1'b0;
      bird_shot_q <= 1'b0;
      flew_away_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fly_q       <= fly_d;
      esc_q       <= esc_d;
      shots_q     <= shots_d;
      score_q     <= score_d;
      bird_idx_q  <= bird_idx_d;
      hits_map_q  <= hits_map_d;
      nsl_q       <= nsl_d;
      bird_shot_q <= (state_d == ST_HIT);
      flew_away_q <= (state_d == ST_GONE);
    end
  end

  assign shots_left    = shots_q;
  assign no_shots_left = nsl_q;
  assign bird_shot     = bird_shot_q;
  assign flew_away     = flew_away_q;
  assign score         = score_q;
  assign bird_idx      = bird_idx_q;
  assign hits_map      = hits_map_q;
  assign trk_state     = 3'(state_q);
  assign game_over     = (bird_idx_q == BIRD_END);

endmodule

// File: tb/tb_round_tracker.sv
// Directed, table-driven bench for round_tracker.
module tb_round_tracker;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick, trigger, hit, new_round;
  logic        reset_shots, reset_score, reset_birds;
  logic [1:0]  shots_left;
  logic        no_shots_left, bird_shot, flew_away, game_over;
  logic [15:0] score;
  logic [3:0]  bird_idx;
  logic [9:0]  hits_map;
  logic [2:0]  trk_state;

  int n_checks = 0;
  int n_err    = 0;

  round_tracker dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .trigger       (trigger),
    .hit           (hit),
    .new_round     (new_round),
    .reset_shots   (reset_shots),
    .reset_score   (reset_score),
    .reset_birds   (reset_birds),
    .shots_left    (shots_left),
    .no_shots_left (no_shots_left),
    .bird_shot     (bird_shot),
    .flew_away     (flew_away),
    .game_over     (game_over),
    .score         (score),
    .bird_idx      (bird_idx),
    .hits_map      (hits_map),
    .trk_state     (trk_state)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ft, tr, ht, nr, rs, rsc, rb;
    logic [1:0]  sl;
    logic        nsl, bs, fa;
    logic [15:0] sc;
    logic [3:0]  idx;
    logic [9:0]  map;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic ft, tr, ht, nr, rs, rsc, rb,
                              input logic [1:0] sl, input logic nsl, bs, fa,
                              input logic [15:0] sc, input logic [3:0] idx,
                              input logic [9:0] map, input logic [2:0] st);
    vec_t v;
    v.ft = ft; v.tr = tr; v.ht = ht; v.nr = nr; v.rs = rs; v.rsc = rsc; v.rb = rb;
    v.sl = sl; v.nsl = nsl; v.bs = bs; v.fa = fa; v.sc = sc; v.idx = idx;
    v.map = map; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] sl, input logic nsl, bs, fa,
                           input logic [15:0] sc, input logic [3:0] idx,
                           input logic [9:0] map, input logic [2:0] st);
    chk({tag, "_shots"}, 32'(shots_left), 32'(sl));
    chk({tag, "_nsl"},   32'(no_shots_left), 32'(nsl));
    chk({tag, "_shot"},  32'(bird_shot), 32'(bs));
    chk({tag, "_flew"},  32'(flew_away), 32'(fa));
    chk({tag, "_score"}, 32'(score), 32'(sc));
    chk({tag, "_idx"},   32'(bird_idx), 32'(idx));
    chk({tag, "_map"},   32'(hits_map), 32'(map));
    chk({tag, "_state"}, 32'(trk_state), 32'(st));
    chk({tag, "_over"},  32'(game_over), 32'(idx == 4'd10));
  endtask

  task automatic apply(input logic ft, tr, ht, nr, rs, rsc, rb);
    frame_tick = ft; trigger = tr; hit = ht; new_round = nr;
    reset_shots = rs; reset_score = rsc; reset_birds = rb;
    @(posedge Clk);
    #1;
    frame_tick = 0; trigger = 0; hit = 0; new_round = 0;
    reset_shots = 0; reset_score = 0; reset_birds = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) apply(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    frame_tick = 0; trigger = 0; hit = 0; new_round = 0;
    reset_shots = 0; reset_score = 0; reset_birds = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //            ft tr ht nr rs rc rb   sl nsl bs fa  score    idx   map             st
    tbl[0]  = mk(0, 0, 0, 1, 1, 0, 0,  3, 0, 0, 0, 16'h0000, 4'd0, 10'b0000000000, 3'd1);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 16'h0000, 4'd0, 10'b0000000000, 3'd1);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0, 16'h0000, 4'd0, 10'b0000000000, 3'd1);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 4'd0, 10'b0000000000, 3'd1);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd2);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd2);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd1);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd1);
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0,  3, 0, 0, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd1);
    tbl[9]  = mk(0, 1, 0, 0, 1, 0, 0,  3, 0, 0, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0,  3, 0, 0, 0, 16'h0000, 4'd1, 10'b0000000001, 3'd1);
    tbl[11] = mk(0, 1, 1, 0, 0, 0, 0,  2, 0, 1, 0, 16'h0500, 4'd2, 10'b0000000011, 3'd2);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 1,  2, 0, 1, 0, 16'h0000, 4'd0, 10'b0000000000, 3'd2);

    do_reset();
    check_all("reset", 3, 0, 0, 0, 16'h0000, 4'd0, 10'd0, 3'd0);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].ft, tbl[i].tr, tbl[i].ht, tbl[i].nr, tbl[i].rs, tbl[i].rsc, tbl[i].rb);
      check_all($sformatf("vec%0d", i), tbl[i].sl, tbl[i].nsl, tbl[i].bs, tbl[i].fa,
                tbl[i].sc, tbl[i].idx, tbl[i].map, tbl[i].st);
    end

    // Hit on frame 10 of a fresh round.
    do_reset();
    apply(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0);
    end
    apply(0, 1, 1, 0, 0, 0, 0);
    check_all("hit10", 2, 0, 1, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd2);

    // Three misses, then the escape timer runs out.
    apply(0, 0, 0, 1, 1, 0, 0);
    repeat (3) apply(0, 1, 0, 0, 0, 0, 0);
    check_all("miss3", 0, 1, 0, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd3);
    ticks(59);
    check_all("esc59", 0, 1, 0, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd3);
    ticks(1);
    check_all("esc60", 0, 1, 0, 1, 16'h0500, 4'd2, 10'b0000000001, 3'd4);

    // Fly timer expiry on the 300th tick.
    apply(0, 0, 0, 1, 1, 0, 0);
    ticks(299);
    check_all("fly299", 3, 0, 0, 0, 16'h0500, 4'd2, 10'b0000000001, 3'd1);
    ticks(1);
    check_all("fly300", 3, 0, 0, 1, 16'h0500, 4'd3, 10'b0000000001, 3'd4);

    // Hit coincident with the 300th tick wins over expiry.
    apply(0, 0, 0, 1, 1, 0, 0);
    ticks(299);
    apply(1, 1, 1, 0, 0, 0, 0);
    check_all("tie_hit", 2, 0, 1, 0, 16'h1000, 4'd4, 10'b0000001001, 3'd2);

    // Miss coincident with expiry stays FLYING one cycle, then GONE.
    apply(0, 0, 0, 1, 1, 0, 0);
    ticks(299);
    apply(1, 1, 0, 0, 0, 0, 0);
    check_all("tie_miss", 2, 0, 0, 0, 16'h1000, 4'd4, 10'b0000001001, 3'd1);
    apply(0, 0, 0, 0, 0, 0, 0);
    check_all("tie_gone", 2, 0, 0, 1, 16'h1000, 4'd5, 10'b0000001001, 3'd4);

    // Ten alternating rounds to game over.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      apply(0, 0, 0, 1, 1, 0, 0);
      if (r % 2 == 0) begin
        apply(0, 1, 1, 0, 0, 0, 0);
        chk($sformatf("rnd%0d_state", r), 32'(trk_state), 32'd2);
      end else begin
        ticks(300);
        chk($sformatf("rnd%0d_state", r), 32'(trk_state), 32'd4);
      end
      chk($sformatf("rnd%0d_idx", r), 32'(bird_idx), 32'(r + 1));
      chk($sformatf("rnd%0d_over", r), 32'(game_over), 32'(r == 9));
    end
    check_all("game", 3, 0, 0, 1, 16'h2500, 4'd10, 10'b0101010101, 3'd4);

    // Score saturates at 9999; bird tally and map stay pinned.
    for (int r = 0; r < 15; r++) begin
      apply(0, 0, 0, 1, 1, 0, 0);
      apply(0, 1, 1, 0, 0, 0, 0);
    end
    check_all("sat", 2, 0, 1, 0, 16'h9999, 4'd10, 10'b0101010101, 3'd2);
    apply(0, 0, 0, 0, 0, 1, 1);
    check_all("clear", 2, 0, 1, 0, 16'h0000, 4'd0, 10'b0000000000, 3'd2);

    // Asynchronous reset mid-round takes effect without a clock edge.
    do_reset();
    apply(0, 0, 0, 1, 1, 0, 0);
    apply(0, 1, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 1, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0);
    check_all("pre_rst", 1, 0, 0, 0, 16'h0500, 4'd1, 10'b0000000001, 3'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_all("async_rst", 3, 0, 0, 0, 16'h0000, 4'd0, 10'd0, 3'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    check_all("post_rst", 3, 0, 0, 0, 16'h0000, 4'd0, 10'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
